// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO write port between NUM_REQ producers.
// Grants are held for a burst ending on req_last or BURST_MAX beats; winc/wData are combinational.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 12,
    parameter int BURST_MAX = 4,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = $clog2(BURST_MAX + 1)
) (
    input  logic                           wclk,
    input  logic                           wrst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wFull,
    output logic                           winc,
    output logic [DATA_SIZE-1:0]           wData,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  rr_last;
    logic [CNT_W-1:0] beat_cnt;

    logic [DATA_SIZE-1:0] data_arr [NUM_REQ];
    logic [ID_W-1:0]      next_owner;
    logic [ID_W-1:0]      cand;
    logic                 found;
    logic                 xfer;
    logic                 burst_end;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end

    // Cyclic search starting just after the last owner; modulo keeps non-power-of-2 counts in range
    always_comb begin
        next_owner = rr_last;
        found      = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_last) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found      = 1'b1;
                next_owner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == GRANT && !wFull) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign xfer      = (state == GRANT) && req_valid[owner] && !wFull;
    assign burst_end = xfer && (req_last[owner] || (beat_cnt == CNT_W'(BURST_MAX - 1)));
    assign winc      = xfer;
    assign wData     = (state == GRANT) ? data_arr[owner] : '0;
    assign busy      = (state == GRANT);
    assign grant_id  = owner;

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_last  <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner    <= next_owner;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A stalled or idle owner keeps the grant; only a completed beat advances the burst
                    if (xfer) begin
                        if (burst_end) begin
                            rr_last  <= owner;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level round-robin model feeding a depth-4 FIFO model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_SIZE = 12;
    localparam int BURST_MAX = 4;
    localparam int WORDS     = 6;
    localparam int FIFO_DEPTH = 4;

    localparam logic [11:0] D0 = 12'h0A1;
    localparam logic [11:0] D1 = 12'h1B2;
    localparam logic [11:0] D3 = 12'h3A5;

    logic        wclk = 1'b0;
    logic        wrst = 1'b0;
    logic [3:0]  req_valid;
    logic [47:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        wFull;
    logic        winc;
    logic [11:0] wData;
    logic [1:0]  grant_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_SIZE(DATA_SIZE),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .wFull    (wFull),
        .winc     (winc),
        .wData    (wData),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [11:0] d2;
        logic        ebusy;
        logic [1:0]  egid;
        logic [3:0]  eready;
        logic        ewinc;
        logic [11:0] ewdata;
    } vec_t;

    vec_t vecs [15];

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic full,
                                 input logic [11:0] d0, input logic [11:0] d1,
                                 input logic [11:0] d2, input logic [11:0] d3);
        req_valid = valid;
        req_last  = last;
        wFull     = full;
        req_data  = {d3, d2, d1, d0};
    endtask

    task automatic checkOutput(input string tag, input logic ebusy, input logic [1:0] egid,
                               input logic [3:0] eready, input logic ewinc, input logic [11:0] ewdata);
        checkVal({tag, ".busy"}, 32'(busy), 32'(ebusy));
        if (ebusy) checkVal({tag, ".grant_id"}, 32'(grant_id), 32'(egid));
        checkVal({tag, ".req_ready"}, 32'(req_ready), 32'(eready));
        checkVal({tag, ".winc"}, 32'(winc), 32'(ewinc));
        checkVal({tag, ".wData"}, 32'(wData), 32'(ewdata));
    endtask

    task automatic nextCycle();
        @(posedge wclk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 4'b0000, 1'b0, D0, D1, 12'h000, D3);
        wrst = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000);
        checkVal("reset.grant_id", 32'(grant_id), 32'd0);
        nextCycle();
        nextCycle();
        wrst = 1'b1;
    endtask

    function automatic logic [11:0] word(input int i, input int s);
        logic [3:0] t;
        logic [7:0] q;
        t = 4'(i);
        q = 8'(s);
        return {t, q};
    endfunction

    // Random-phase producer and FIFO model state
    int          nxt [4];
    logic        pv [4];
    logic        last_tbl [4][WORDS];
    logic [11:0] fifo_q [$];
    logic [11:0] grant_log [$];
    logic        m_busy;
    int          m_owner;
    int          m_rr;
    int          m_beats;

    initial begin
        int          winc_count;
        int          reads;
        logic        e_winc;
        logic [3:0]  e_ready;
        logic [11:0] e_wdata;
        logic        dut_push;
        logic [11:0] dut_word;
        logic [11:0] popped;
        logic        done;
        int          o;

        vecs[0]  = '{4'b0100, 4'b0000, 1'b0, 12'h101, 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000};
        vecs[1]  = '{4'b0100, 4'b0000, 1'b0, 12'h101, 1'b1, 2'd2, 4'b0100, 1'b1, 12'h101};
        vecs[2]  = '{4'b0100, 4'b0000, 1'b0, 12'h102, 1'b1, 2'd2, 4'b0100, 1'b1, 12'h102};
        vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 12'h103, 1'b1, 2'd2, 4'b0100, 1'b1, 12'h103};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 12'h103, 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000};
        vecs[5]  = '{4'b1101, 4'b0000, 1'b0, 12'h1FF, 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000};
        vecs[6]  = '{4'b1101, 4'b0000, 1'b0, 12'h1FF, 1'b1, 2'd3, 4'b1000, 1'b1, D3};
        vecs[7]  = '{4'b1101, 4'b0000, 1'b1, 12'h1FF, 1'b1, 2'd3, 4'b0000, 1'b0, D3};
        vecs[8]  = '{4'b1101, 4'b1000, 1'b0, 12'h1FF, 1'b1, 2'd3, 4'b1000, 1'b1, D3};
        vecs[9]  = '{4'b0101, 4'b0000, 1'b0, 12'h1FF, 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000};
        vecs[10] = '{4'b0101, 4'b0000, 1'b0, 12'h1FF, 1'b1, 2'd0, 4'b0001, 1'b1, D0};
        vecs[11] = '{4'b0100, 4'b0000, 1'b0, 12'h1FF, 1'b1, 2'd0, 4'b0001, 1'b0, D0};
        vecs[12] = '{4'b0101, 4'b0001, 1'b0, 12'h1FF, 1'b1, 2'd0, 4'b0001, 1'b1, D0};
        vecs[13] = '{4'b0100, 4'b0000, 1'b0, 12'h1FF, 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000};
        vecs[14] = '{4'b0100, 4'b0000, 1'b0, 12'h1FF, 1'b1, 2'd2, 4'b0100, 1'b1, 12'h1FF};

        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].full, D0, D1, vecs[i].d2, D3);
            @(negedge wclk);
            checkOutput($sformatf("vec%0d", i), vecs[i].ebusy, vecs[i].egid, vecs[i].eready,
                        vecs[i].ewinc, vecs[i].ewdata);
            nextCycle();
        end

        // All requesters always valid: bursts cut at BURST_MAX and priority rotates 0,1,2,3,0
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b0, D0, D1, 12'h2C4, D3);
        for (int b = 0; b < 5; b++) begin
            logic [11:0] dexp;
            int g;
            g = b % NUM_REQ;
            dexp = (g == 0) ? D0 : (g == 1) ? D1 : (g == 2) ? 12'h2C4 : D3;
            @(negedge wclk);
            checkOutput($sformatf("rot%0d.idle", b), 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000);
            nextCycle();
            for (int k = 0; k < BURST_MAX; k++) begin
                @(negedge wclk);
                checkOutput($sformatf("rot%0d.beat%0d", b, k), 1'b1, 2'(g), 4'(1 << g), 1'b1, dexp);
                nextCycle();
            end
        end

        // wFull held high for 5 cycles after beat 2
        doReset();
        winc_count = 0;
        applyStimulus(4'b0001, 4'b0000, 1'b0, D0, D1, 12'h000, D3);
        for (int c = 0; c < 10; c++) begin
            wFull = (c >= 3 && c < 8);
            @(negedge wclk);
            winc_count += int'(winc);
            if (c >= 3 && c < 8) begin
                checkOutput($sformatf("stall%0d", c), 1'b1, 2'd0, 4'b0000, 1'b0, D0);
            end
            nextCycle();
        end
        @(negedge wclk);
        checkVal("stall.idle_after", 32'(busy), 32'd0);
        checkVal("stall.winc_count", 32'(winc_count), 32'd4);
        nextCycle();

        // Asynchronous reset in the middle of requester 1's burst
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0, D0, D1, 12'h000, D3);
        nextCycle();
        nextCycle();
        @(negedge wclk);
        checkOutput("rst_mid.pre", 1'b1, 2'd1, 4'b0010, 1'b1, D1);
        nextCycle();
        #2;
        wrst = 1'b0;
        #1;
        checkOutput("rst_mid.async", 1'b0, 2'd0, 4'b0000, 1'b0, 12'h000);
        checkVal("rst_mid.grant_id", 32'(grant_id), 32'd0);
        nextCycle();
        wrst = 1'b1;
        applyStimulus(4'b1010, 4'b0000, 1'b0, D0, D1, 12'h000, D3);
        nextCycle();
        @(negedge wclk);
        checkOutput("rst_mid.regrant", 1'b1, 2'd1, 4'b0010, 1'b1, D1);
        nextCycle();

        // Randomized end-to-end run: 4 producers x 6 tagged words into a depth-4 FIFO with a stalled reader
        doReset();
        for (int i = 0; i < NUM_REQ; i++) begin
            nxt[i] = 0;
            pv[i]  = 1'b0;
            for (int s = 0; s < WORDS; s++) begin
                last_tbl[i][s] = (s == WORDS - 1) || ($urandom_range(0, 3) == 0);
            end
        end
        fifo_q.delete();
        grant_log.delete();
        m_busy  = 1'b0;
        m_owner = 0;
        m_rr    = NUM_REQ - 1;
        m_beats = 0;
        reads   = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pv[i] && nxt[i] < WORDS && $urandom_range(0, 1) == 1) pv[i] = 1'b1;
                req_valid[i] = pv[i];
                req_last[i]  = (nxt[i] < WORDS) ? last_tbl[i][nxt[i]] : 1'b0;
                req_data[i*DATA_SIZE +: DATA_SIZE] = word(i, nxt[i]);
            end
            wFull = (fifo_q.size() >= FIFO_DEPTH);

            e_ready = (m_busy && !wFull) ? 4'(1 << m_owner) : 4'b0000;
            e_winc  = m_busy && !wFull && pv[m_owner];
            e_wdata = m_busy ? word(m_owner, nxt[m_owner]) : 12'h000;

            @(negedge wclk);
            checkOutput($sformatf("rnd%0d", cyc), m_busy, 2'(m_owner), e_ready, e_winc, e_wdata);
            if (winc && wFull) begin
                checkVal("rnd.write_when_full", 32'(winc && wFull), 32'd0);
            end
            dut_push = winc;
            dut_word = wData;
            nextCycle();

            if (e_winc) begin
                o = m_owner;
                grant_log.push_back(e_wdata);
                m_beats++;
                if (last_tbl[o][nxt[o]] || m_beats == BURST_MAX) begin
                    m_rr   = o;
                    m_busy = 1'b0;
                end
                pv[o] = 1'b0;
                nxt[o]++;
            end else if (!m_busy) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int cand;
                    cand = (m_rr + k) % NUM_REQ;
                    if (!m_busy && pv[cand]) begin
                        m_busy  = 1'b1;
                        m_owner = cand;
                        m_beats = 0;
                    end
                end
            end

            if (cyc >= 40 && fifo_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                popped = fifo_q.pop_front();
                reads++;
                if (grant_log.size() == 0) begin
                    checkVal("rnd.drain_unexpected", 32'(popped), 32'hFFFF_FFFF);
                end else begin
                    checkVal("rnd.drain_order", 32'(popped), 32'(grant_log.pop_front()));
                end
            end
            if (dut_push) fifo_q.push_back(dut_word);

            done = !m_busy && fifo_q.size() == 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (nxt[i] < WORDS) done = 1'b0;
            end
        end
        checkVal("rnd.completed", 32'(done), 32'd1);
        checkVal("rnd.words_read", 32'(reads), 32'(NUM_REQ * WORDS));
        checkVal("rnd.log_empty", 32'(grant_log.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
